// File: rtl/multi_key_hold.sv
// N-channel push-button front end: two-flop synchroniser, debounce, long-hold
// detection and optional auto-repeat for each active-low key.
module multi_key_hold #(
   parameter int N             = 4,
   parameter int DEB_CYCLES    = 1000,
   parameter int HOLD_CYCLES   = 2500000,
   parameter int REPEAT_CYCLES = 500000,
   parameter int CW            = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] key_n,
   input  logic         repeat_en,
   input  logic         clear,
   output logic [N-1:0] press_pulse,
   output logic [N-1:0] held_n,
   output logic [N-1:0] repeat_pulse,
   output logic         any_held
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      HELD     = 2'd3
   } state_t;

   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [CW-1:0] DEB_C  = CW'(DEB_CYCLES);
   localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] REP_C  = CW'(REPEAT_CYCLES);

   logic [N-1:0] sync1_q;
   logic [N-1:0] sync2_q;
   logic         any_held_q;
   logic         any_held_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         state_t        state_q;
         state_t        state_d;
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;
         logic [CW-1:0] cnt_inc;
         logic          press_q;
         logic          press_d;
         logic          rep_q;
         logic          rep_d;
         logic          held_n_q;
         logic          held_n_d;
         logic          key_s;

         assign key_s   = sync2_q[gi];
         assign cnt_inc = cnt_q + ONE_C;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               state_q  <= IDLE;
               cnt_q    <= '0;
               press_q  <= 1'b0;
               rep_q    <= 1'b0;
               held_n_q <= 1'b1;
            end else begin
               state_q  <= state_d;
               cnt_q    <= cnt_d;
               press_q  <= press_d;
               rep_q    <= rep_d;
               held_n_q <= held_n_d;
            end
         end

         // cnt_inc is the run length k (relative to the state's origin)
         // including the low sample seen at this edge.
         always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rep_d   = 1'b0;
            if (clear || key_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               case (state_q)
                  IDLE, DEBOUNCE: begin
                     if (cnt_inc == DEB_C) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                     end else begin
                        state_d = DEBOUNCE;
                        cnt_d   = cnt_inc;
                     end
                  end
                  PRESSED: begin
                     if (cnt_inc == HOLD_C) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        rep_d   = repeat_en;
                     end else begin
                        cnt_d = cnt_inc;
                     end
                  end
                  HELD: begin
                     if (!repeat_en) begin
                        cnt_d = '0;
                     end else if (cnt_inc == REP_C) begin
                        cnt_d = '0;
                        rep_d = 1'b1;
                     end else begin
                        cnt_d = cnt_inc;
                     end
                  end
                  default: begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               endcase
            end
            held_n_d = (state_d != HELD);
         end

         assign press_pulse[gi]  = press_q;
         assign repeat_pulse[gi] = rep_q;
         assign held_n[gi]       = held_n_q;
      end
   endgenerate

   // Registered summary: deliberately one cycle behind held_n.
   assign any_held_d = ~(&held_n);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         any_held_q <= 1'b0;
      end else begin
         any_held_q <= any_held_d;
      end
   end

   assign any_held = any_held_q;

endmodule

// File: tb/tb_multi_key_hold.sv
// Self-checking bench for multi_key_hold: directed scenarios plus random key
// activity, compared every cycle against a run-length reference model.
module tb_multi_key_hold;
   localparam int N    = 2;
   localparam int DEB  = 4;
   localparam int HOLD = 10;
   localparam int REP  = 3;
   localparam int CW   = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] key_n = '1;
   logic         repeat_en = 1'b0;
   logic         clear = 1'b0;
   logic [N-1:0] press_pulse;
   logic [N-1:0] held_n;
   logic [N-1:0] repeat_pulse;
   logic         any_held;

   int checks = 0;
   int failures = 0;

   // Reference model state: synchroniser history and per-channel run lengths.
   logic [N-1:0] m_s1, m_s2;
   logic [N-1:0] exp_press, exp_rep, exp_held;
   logic         exp_any;
   int           k_run[N];
   int           r_run[N];
   int           pc[N];
   int           rc[N];

   multi_key_hold #(
      .N(N), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CW(CW)
   ) dut (
      .clk(clk), .reset(reset), .key_n(key_n), .repeat_en(repeat_en),
      .clear(clear), .press_pulse(press_pulse), .held_n(held_n),
      .repeat_pulse(repeat_pulse), .any_held(any_held)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_s1 = '1;
      m_s2 = '1;
      exp_press = '0;
      exp_rep = '0;
      exp_held = '0;
      exp_any = 1'b0;
      for (int c = 0; c < N; c++) begin
         k_run[c] = 0;
         r_run[c] = 0;
      end
   endtask

   task automatic model_step();
      logic [N-1:0] ks;
      ks = m_s2;
      exp_any = |exp_held;
      m_s2 = m_s1;
      m_s1 = key_n;
      for (int c = 0; c < N; c++) begin
         exp_press[c] = 1'b0;
         exp_rep[c] = 1'b0;
         if (clear || ks[c]) begin
            k_run[c] = 0;
            r_run[c] = 0;
         end else begin
            if (k_run[c] <= DEB + HOLD) k_run[c]++;
            exp_press[c] = (k_run[c] == DEB);
            if (k_run[c] == DEB + HOLD) begin
               exp_rep[c] = repeat_en;
               r_run[c] = 0;
            end else if (k_run[c] > DEB + HOLD) begin
               if (repeat_en) begin
                  r_run[c]++;
                  if (r_run[c] == REP) begin
                     exp_rep[c] = 1'b1;
                     r_run[c] = 0;
                  end
               end else begin
                  r_run[c] = 0;
               end
            end
         end
         exp_held[c] = (k_run[c] >= DEB + HOLD);
      end
   endtask

   task automatic check_outputs(string tag);
      checks++;
      assert (press_pulse === exp_press) else begin
         failures++;
         $error("FAIL %s press_pulse got=%b exp=%b", tag, press_pulse, exp_press);
      end
      checks++;
      assert (repeat_pulse === exp_rep) else begin
         failures++;
         $error("FAIL %s repeat_pulse got=%b exp=%b", tag, repeat_pulse, exp_rep);
      end
      checks++;
      assert (held_n === ~exp_held) else begin
         failures++;
         $error("FAIL %s held_n got=%b exp=%b", tag, held_n, ~exp_held);
      end
      checks++;
      assert (any_held === exp_any) else begin
         failures++;
         $error("FAIL %s any_held got=%b exp=%b", tag, any_held, exp_any);
      end
   endtask

   task automatic check_int(string tag, int got, int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      for (int c = 0; c < N; c++) begin
         pc[c] = 0;
         rc[c] = 0;
      end
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      model_step();
      #1;
      check_outputs(tag);
      for (int c = 0; c < N; c++) begin
         pc[c] += int'(press_pulse[c]);
         rc[c] += int'(repeat_pulse[c]);
      end
   endtask

   task automatic idle_ticks(int n);
      key_n = '1;
      for (int i = 0; i < n; i++) tick("idle");
   endtask

   initial begin
      int first_press, first_held, first_any, second_press;
      int rq[$];
      int exp_e[4];
      int run[N];

      exp_e = '{15, 18, 28, 31};
      model_reset();
      clear_counts();

      // Reset state
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      reset = 1'b1;
      $display("step reset: released");
      idle_ticks(3);

      // 1: clean press, 6 low edges
      clear_counts();
      first_press = -1;
      for (int e = 0; e < 12; e++) begin
         key_n[0] = (e < 6) ? 1'b0 : 1'b1;
         tick("t1_press");
         if (press_pulse[0] && first_press < 0) first_press = e;
      end
      check_int("t1_press_edge", first_press, 5);
      check_int("t1_press_count", pc[0], 1);
      check_int("t1_ch1_press", pc[1], 0);
      $display("step 1: press edge=%0d count=%0d", first_press, pc[0]);

      // 2: bounce 3 low, 1 high, 3 low
      clear_counts();
      for (int e = 0; e < 12; e++) begin
         key_n[0] = (e < 3 || (e >= 4 && e < 7)) ? 1'b0 : 1'b1;
         tick("t2_bounce");
      end
      check_int("t2_no_press", pc[0], 0);
      $display("step 2: bounce presses=%0d", pc[0]);

      // 3: long hold on channel 1, repeat disabled
      clear_counts();
      repeat_en = 1'b0;
      first_held = -1;
      first_any = -1;
      for (int e = 0; e < 38; e++) begin
         key_n[1] = (e < 30) ? 1'b0 : 1'b1;
         tick("t3_hold");
         if (!held_n[1] && first_held < 0) first_held = e;
         if (any_held && first_any < 0) first_any = e;
      end
      check_int("t3_held_edge", first_held, 15);
      check_int("t3_any_edge", first_any, 16);
      check_int("t3_press_count", pc[1], 1);
      check_int("t3_repeat_count", rc[1], 0);
      $display("step 3: held at E%0d any at E%0d", first_held, first_any);

      // 4: long hold with repeat, enable dropped after E19 and restored after E25
      clear_counts();
      rq.delete();
      for (int e = 0; e < 38; e++) begin
         key_n[1] = (e < 30) ? 1'b0 : 1'b1;
         repeat_en = (e < 20 || e >= 26) ? 1'b1 : 1'b0;
         tick("t4_repeat");
         if (repeat_pulse[1]) rq.push_back(e);
      end
      repeat_en = 1'b0;
      check_int("t4_repeat_count", rq.size(), 4);
      if (rq.size() == 4) begin
         for (int i = 0; i < 4; i++) check_int("t4_repeat_edge", rq[i], exp_e[i]);
      end
      $display("step 4: repeat pulses=%0d", rq.size());

      // 5: both keys low, clear at E10
      clear_counts();
      second_press = -1;
      for (int e = 0; e < 18; e++) begin
         key_n = '0;
         clear = (e == 10) ? 1'b1 : 1'b0;
         tick("t5_clear");
         if (e > 10 && press_pulse == 2'b11 && second_press < 0) second_press = e;
      end
      clear = 1'b0;
      check_int("t5_second_press", second_press, 14);
      check_int("t5_press_ch0", pc[0], 2);
      check_int("t5_press_ch1", pc[1], 2);
      $display("step 5: second press pair at E%0d", second_press);
      idle_ticks(4);

      // 6: async reset while channel 0 is HELD
      key_n = 2'b10;
      for (int e = 0; e < 20; e++) tick("t6_hold");
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_int("t6_rst_held_n", int'(held_n), 3);
      check_int("t6_rst_press", int'(press_pulse), 0);
      check_int("t6_rst_repeat", int'(repeat_pulse), 0);
      check_int("t6_rst_any", int'(any_held), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      clear_counts();
      first_press = -1;
      for (int i = 1; i <= 10; i++) begin
         tick("t6_reacquire");
         if (press_pulse[0] && first_press < 0) first_press = i;
      end
      check_int("t6_reacquire_edge", first_press, 2 + DEB);
      $display("step 6: re-acquired press at tick %0d", first_press);
      idle_ticks(4);

      // Random key activity against the model
      for (int c = 0; c < N; c++) run[c] = 0;
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < N; c++) begin
            if (run[c] == 0) begin
               key_n[c] = ~key_n[c];
               run[c] = key_n[c] ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 24));
            end
            run[c]--;
         end
         if ($urandom_range(0, 19) == 0) repeat_en = ~repeat_en;
         clear = ($urandom_range(0, 59) == 0);
         tick("random");
      end
      clear = 1'b0;
      $display("step random: 600 cycles done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_key_hold.md
Name: multi_key_hold

Overview:
- Parametrised N-channel push-button front end: synchronises, debounces and hold-detects active-low key inputs.
- Each channel produces:
  - a one-cycle press pulse after debounce;
  - an active-low "held" level after a long hold;
  - optional auto-repeat pulses while the key stays held.
- Sits between board push-buttons and lab control FSMs (load/start/step keys). Replaces per-key single-threshold hold detectors.

Parameters:
- N, 4, number of independent key channels (>=1)
- DEB_CYCLES, 1000, consecutive low samples required to accept a press (>=1)
- HOLD_CYCLES, 2500000, further consecutive low samples after debounce before held_n asserts (>=1)
- REPEAT_CYCLES, 500000, interval between auto-repeat pulses while held (>=1)
- CW, 32, per-channel counter width; must hold max(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- key_n  in  N  raw asynchronous keys, 0 = pressed
- repeat_en  in  1  global auto-repeat enable, synchronous
- clear  in  1  synchronous; forces every channel to IDLE
- press_pulse  out  N  one-cycle pulse per accepted press
- held_n  out  N  0 while channel is in HELD, else 1
- repeat_pulse  out  N  one-cycle auto-repeat pulses
- any_held  out  1  1 when any held_n bit is 0 (registered)

Behaviour:
- Reset (async, reset=0):
  - synchroniser flops = 1
  - all FSMs = IDLE, counters = 0
  - held_n = all 1, press_pulse = 0, repeat_pulse = 0, any_held = 0
- Synchroniser: per channel, two flops; key_s = second-stage output.
- Channel FSM states: IDLE, DEBOUNCE, PRESSED, HELD. All outputs are registered.
- Define k = number of consecutive clock edges at which the FSM sampled key_s = 0. Edge E0 is the edge that first captures key_n = 0 into stage 1; the FSM first samples key_s = 0 at E2 (k = 1).
- IDLE:
  - key_s = 0 -> DEBOUNCE, cnt = 1.
- DEBOUNCE:
  - key_s = 1 -> IDLE, cnt = 0, no output.
  - Otherwise cnt++.
  - When k = DEB_CYCLES: -> PRESSED, press_pulse = 1 for exactly one cycle, cnt = 0.
  - With DEB_CYCLES = 1, IDLE goes directly to PRESSED at k = 1.
- PRESSED:
  - key_s = 1 -> IDLE.
  - When k = DEB_CYCLES + HOLD_CYCLES: -> HELD, held_n = 0, cnt = 0.
  - At that same edge, repeat_pulse = 1 if repeat_en = 1.
- HELD:
  - key_s = 1 -> IDLE; held_n returns to 1 at that same edge.
  - repeat_en = 1: cnt++; repeat_pulse fires whenever cnt reaches REPEAT_CYCLES, then cnt = 0.
  - repeat_en = 0: cnt held at 0, no pulses. Re-enabling restarts the full REPEAT_CYCLES interval.
- Release has no debounce: the first key_s = 1 sample returns the channel to IDLE.
  - A bounce after the press is accepted ends the press.
  - A new press requires a full DEB_CYCLES again.
- clear = 1:
  - all channels go to IDLE, cnt = 0, held_n = 1, no pulses that cycle.
  - clear has priority over key activity.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- any_held = registered OR of ~held_n; it lags held_n by one cycle.
- Counters never wrap: cnt is reset at every state transition and never exceeds its compare value.
- Async reset mid-operation aborts immediately to reset values; no pulse is emitted on reset release.

Test Plan:
(Parameters: N=2, DEB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, repeat_en=0 unless stated.)
1. key_n[0] low from E0 for 6 edges, then high -> press_pulse[0] high exactly one cycle after E5; held_n[0] stays 1; channel 1 outputs all 0.
2. key_n[0] low 3 edges, high 1 edge, low 3 edges (bounce) -> no press_pulse, held_n[0] = 1 throughout.
3. key_n[1] held low 30 edges, repeat_en=0 -> press_pulse[1] after E5; held_n[1] = 0 from E15; any_held = 1 from E16; release -> held_n[1] = 1 two edges after key_n rises, no repeat_pulse.
4. Same as 3 with repeat_en=1 -> repeat_pulse[1] after E15, E18, E21, E24, ... until release; dropping repeat_en at E19 suppresses the E21 pulse and later ones; restoring it at E25 gives the next pulse at E28.
5. Both keys low simultaneously, clear=1 at E10 for one cycle -> both channels return to IDLE; held_n stays 1; next press_pulse pair appears 4 samples after E10.
6. Channel 0 in HELD, reset=0 asynchronously mid-cycle -> held_n = 11, pulses = 0 immediately; after reset=1 with key still low, press_pulse only after a full 2 + DEB_CYCLES re-acquisition.
